// File: rtl/dac_rp_stream.sv
// dac_rp_stream: streaming DAC front-end. Takes CHANNELS signed samples per
// beat over a valid/ready stream and buffers them in a show-ahead FIFO. A
// startup/underrun state machine waits for PLL lock and a FIFO prime level
// before it starts playout. Each popped beat is arithmetic-shifted, saturated
// to DAC_WIDTH and registered toward the ODDR/PLL pin layer.
//
// Optional feature macro: DAC_RP_STREAM_HOLD_EN
//   defined   - in UNDERRUN, dac_data holds the last popped sample
//   undefined - in UNDERRUN, dac_data is driven to 0
//
// Ports:
//   clk, rst_n        clock (DAC sample rate), async active-low reset
//   enable            playout enable; low flushes and idles the block
//   pll_locked        DDR-clock PLL lock, synchronous to clk
//   s_tdata/tvalid    input beat, channel 0 in LSBs
//   s_tready          input ready (combinational from registered state/level)
//   dac_data          registered output words, channel 0 in LSBs
//   dac_valid         dac_data holds a popped sample this cycle
//   state             IDLE=0 WAIT_LOCK=1 PRIME=2 RUN=3 UNDERRUN=4
//   fifo_level        FIFO occupancy
//   underrun_cnt      saturating count of RUN->UNDERRUN events
//   sat_flag          sticky per-channel saturation flags
module dac_rp_stream #(
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned DAC_WIDTH   = 14,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned PRIME_LEVEL = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            pll_locked,
  input  logic [CHANNELS*IN_WIDTH-1:0]    s_tdata,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  output logic [CHANNELS*DAC_WIDTH-1:0]   dac_data,
  output logic                            dac_valid,
  output logic [2:0]                      state,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]            underrun_cnt,
  output logic [CHANNELS-1:0]             sat_flag
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned DATA_W = CHANNELS * IN_WIDTH;
  localparam int unsigned OUT_W  = CHANNELS * DAC_WIDTH;
  localparam int unsigned EXT_W  = IN_WIDTH + DAC_WIDTH;

  // Clip bounds, sign-extended to the working width.
  localparam logic signed [EXT_W-1:0] C_MAX =
    {{(IN_WIDTH+1){1'b0}}, {(DAC_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] C_MIN =
    {{(IN_WIDTH+1){1'b1}}, {(DAC_WIDTH-1){1'b0}}};
  localparam logic [DAC_WIDTH-1:0] C_MAX_OUT = {1'b0, {(DAC_WIDTH-1){1'b1}}};
  localparam logic [DAC_WIDTH-1:0] C_MIN_OUT = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_PRIME     = 3'd2,
    ST_RUN       = 3'd3,
    ST_UNDERRUN  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [PW-1:0]         r_level;

  logic [OUT_W-1:0]      r_dac_data;
  logic                  r_dac_valid;
  logic [CNT_WIDTH-1:0]  r_ucnt;
  logic [CHANNELS-1:0]   r_sat;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_primed;
  logic                  w_flush;
  logic                  w_clr_sat;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_underrun;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_head;
  logic [OUT_W-1:0]      w_scaled;
  logic [CHANNELS-1:0]   w_clip;
  logic [OUT_W-1:0]      w_fill;
  logic [OUT_W-1:0]      w_dac_nxt;
  logic                  w_valid_nxt;
  logic signed [EXT_W-1:0] w_xe;
  logic signed [EXT_W-1:0] w_y;
  logic [DAC_WIDTH-1:0]  w_ch;

  // FIFO status: the extra pointer MSB separates full from empty.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_primed = (r_level >= PW'(PRIME_LEVEL));
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  assign w_ready  = !w_full && ((r_state == ST_PRIME) || (r_state == ST_RUN) ||
                                (r_state == ST_UNDERRUN));
  // A beat presented during a flush cycle is dropped.
  assign w_push   = s_tvalid && w_ready && !w_flush;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, FIFO control and next output word.
  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    w_clr_sat   = 1'b0;
    w_pop       = 1'b0;
    w_underrun  = 1'b0;
    w_dac_nxt   = '0;
    w_valid_nxt = 1'b0;
`ifdef DAC_RP_STREAM_HOLD_EN
    w_fill      = r_dac_data;
`else
    w_fill      = '0;
`endif

    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_flush     = 1'b1;
      w_clr_sat   = 1'b1;
    end else if (!pll_locked) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:      w_state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: w_state_nxt = ST_PRIME;
        ST_PRIME: begin
          if (w_primed) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_empty) begin
            w_state_nxt = ST_UNDERRUN;
            w_underrun  = 1'b1;
          end else begin
            w_pop = 1'b1;
          end
        end
        ST_UNDERRUN: begin
          if (w_primed) w_state_nxt = ST_RUN;
        end
        default:      w_state_nxt = ST_IDLE;
      endcase
    end

    // Playout states without a pop show the fill value; others show zero.
    if (w_pop) begin
      w_dac_nxt   = w_scaled;
      w_valid_nxt = 1'b1;
    end else if ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_UNDERRUN)) begin
      w_dac_nxt   = w_fill;
    end
  end

  // Per-channel arithmetic shift and saturation of the FIFO head.
  always_comb begin
    w_scaled = '0;
    w_clip   = '0;
    w_xe     = '0;
    w_y      = '0;
    w_ch     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_xe = {{DAC_WIDTH{w_head[c*IN_WIDTH + IN_WIDTH - 1]}},
              w_head[c*IN_WIDTH +: IN_WIDTH]};
      w_y  = w_xe >>> SHIFT;
      if (w_y > C_MAX) begin
        w_ch      = C_MAX_OUT;
        w_clip[c] = 1'b1;
      end else if (w_y < C_MIN) begin
        w_ch      = C_MIN_OUT;
        w_clip[c] = 1'b1;
      end else begin
        w_ch      = w_y[DAC_WIDTH-1:0];
      end
      w_scaled[c*DAC_WIDTH +: DAC_WIDTH] = w_ch;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= s_tdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + PW'(1);
        2'b01:   r_level <= r_level - PW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Output words, underrun counter and sticky saturation flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dac_data  <= '0;
      r_dac_valid <= 1'b0;
      r_ucnt      <= '0;
      r_sat       <= '0;
    end else begin
      r_dac_data  <= w_dac_nxt;
      r_dac_valid <= w_valid_nxt;
      if (w_underrun && (r_ucnt != {CNT_WIDTH{1'b1}})) begin
        r_ucnt <= r_ucnt + CNT_WIDTH'(1);
      end
      if (w_clr_sat) begin
        r_sat <= '0;
      end else if (w_pop) begin
        r_sat <= r_sat | w_clip;
      end
    end
  end

  assign s_tready     = w_ready;
  assign dac_data     = r_dac_data;
  assign dac_valid    = r_dac_valid;
  assign state        = r_state;
  assign fifo_level   = r_level;
  assign underrun_cnt = r_ucnt;
  assign sat_flag     = r_sat;

endmodule

// File: tb/tb_dac_rp_stream.sv
// Bench for dac_rp_stream: instance a uses defaults, instance b uses
// SHIFT=2 and PRIME_LEVEL=16. Both share stimulus and are compared every
// cycle against a queue-based reference model, plus table and hand checks.
module tb_dac_rp_stream;

  logic        clk = 1'b0;
  logic        rst_n, enable, pll_locked, s_tvalid;
  logic [31:0] s_tdata;

  logic        a_tready, b_tready, a_valid, b_valid;
  logic [27:0] a_data, b_data;
  logic [2:0]  a_state, b_state;
  logic [4:0]  a_level, b_level;
  logic [15:0] a_ucnt, b_ucnt;
  logic [1:0]  a_sat, b_sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dac_rp_stream u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pll_locked(pll_locked),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(a_tready),
    .dac_data(a_data), .dac_valid(a_valid), .state(a_state),
    .fifo_level(a_level), .underrun_cnt(a_ucnt), .sat_flag(a_sat)
  );

  dac_rp_stream #(.SHIFT(2), .PRIME_LEVEL(16)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pll_locked(pll_locked),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(b_tready),
    .dac_data(b_data), .dac_valid(b_valid), .state(b_state),
    .fifo_level(b_level), .underrun_cnt(b_ucnt), .sat_flag(b_sat)
  );

  // Input pair with hand-derived outputs for SHIFT=0 (a) and SHIFT=2 (b).
  typedef struct {
    logic [15:0] x0, x1;
    logic [13:0] a0, a1, b0, b1;
  } vec_t;
  vec_t tbl [6];

  // Reference model state, index 0 = a, 1 = b.
  int          m_st   [2];
  logic [27:0] m_data [2];
  logic        m_valid[2];
  int          m_ucnt [2];
  logic [1:0]  m_sat  [2];
  int          m_pl   [2];
  int          m_sh   [2];
  logic [31:0] m_q0 [$];
  logic [31:0] m_q1 [$];

  // Table scoreboard.
  bit          tbl_mode = 1'b0;
  int          cur_idx  = 0;
  logic [27:0] sb_a [$];
  logic [27:0] sb_b [$];
  int          sb_acc [2];
  int          sb_out [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? m_q0.size() : m_q1.size();
  endfunction

  function automatic logic model_ready(input int i);
    return (qsize(i) < 16) && (m_st[i] >= 2) && (m_st[i] <= 4);
  endfunction

  // Returns {clip, 14-bit word}.
  function automatic logic [14:0] scale(input logic [15:0] x, input int sh);
    int   v;
    logic clip;
    v    = int'($signed(x)) >>> sh;
    clip = 1'b0;
    if (v > 8191) begin
      v = 8191; clip = 1'b1;
    end else if (v < -8192) begin
      v = -8192; clip = 1'b1;
    end
    return {clip, 14'(v)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_data[i] = '0; m_valid[i] = 1'b0; m_ucnt[i] = 0; m_sat[i] = '0;
    end
    m_q0.delete();
    m_q1.delete();
  endtask

  task automatic model_step(input int i, input logic en, input logic lk,
                            input logic tv, input logic [31:0] td);
    int          sz;
    logic        rdy;
    logic [31:0] head;
    logic [14:0] r0, r1;
    logic [27:0] fill;
    sz  = qsize(i);
    rdy = model_ready(i);
`ifdef DAC_RP_STREAM_HOLD_EN
    fill = m_data[i];
`else
    fill = '0;
`endif
    m_valid[i] = 1'b0;
    if (!en || !lk) begin
      m_st[i]   = en ? 1 : 0;
      m_data[i] = '0;
      if (!en) m_sat[i] = '0;
      if (i == 0) m_q0.delete(); else m_q1.delete();
    end else begin
      case (m_st[i])
        0: begin m_st[i] = 1; m_data[i] = '0; end
        1: begin m_st[i] = 2; m_data[i] = '0; end
        2: begin if (sz >= m_pl[i]) m_st[i] = 3; m_data[i] = '0; end
        3: begin
          if (sz == 0) begin
            m_st[i] = 4;
            if (m_ucnt[i] < 65535) m_ucnt[i]++;
            m_data[i] = fill;
          end else begin
            if (i == 0) head = m_q0.pop_front(); else head = m_q1.pop_front();
            r0 = scale(head[15:0], m_sh[i]);
            r1 = scale(head[31:16], m_sh[i]);
            m_data[i]  = {r1[13:0], r0[13:0]};
            m_valid[i] = 1'b1;
            m_sat[i]   = m_sat[i] | {r1[14], r0[14]};
          end
        end
        default: begin if (sz >= m_pl[i]) m_st[i] = 3; m_data[i] = fill; end
      endcase
      if (tv && rdy) begin
        if (i == 0) m_q0.push_back(td); else m_q1.push_back(td);
      end
    end
  endtask

  task automatic check_model(input string p, input int i, input logic [2:0] st,
                             input logic [4:0] lv, input logic v, input logic [27:0] d,
                             input logic [15:0] u, input logic [1:0] s);
    check({p, ".state"},  32'(st), 32'(m_st[i]));
    check({p, ".level"},  32'(lv), 32'(qsize(i)));
    check({p, ".valid"},  32'(v),  32'(m_valid[i]));
    check({p, ".data"},   32'(d),  32'(m_data[i]));
    check({p, ".ucnt"},   32'(u),  32'(m_ucnt[i]));
    check({p, ".sat"},    32'(s),  32'(m_sat[i]));
  endtask

  // One clock: check ready before the edge, step model, check outputs after.
  task automatic tick();
    logic ra, rb;
    ra = model_ready(0);
    rb = model_ready(1);
    check("a.s_tready", 32'(a_tready), 32'(ra));
    check("b.s_tready", 32'(b_tready), 32'(rb));
    if (tbl_mode && s_tvalid && enable && pll_locked) begin
      if (ra) begin sb_a.push_back({tbl[cur_idx].a1, tbl[cur_idx].a0}); sb_acc[0]++; end
      if (rb) begin sb_b.push_back({tbl[cur_idx].b1, tbl[cur_idx].b0}); sb_acc[1]++; end
    end
    @(posedge clk);
    model_step(0, enable, pll_locked, s_tvalid, s_tdata);
    model_step(1, enable, pll_locked, s_tvalid, s_tdata);
    #1;
    check_model("a", 0, a_state, a_level, a_valid, a_data, a_ucnt, a_sat);
    check_model("b", 1, b_state, b_level, b_valid, b_data, b_ucnt, b_sat);
    if (tbl_mode) begin
      if (a_valid) begin
        if (sb_a.size() == 0) fail_now("a.table_extra");
        else check("a.table", 32'(a_data), 32'(sb_a.pop_front()));
        sb_out[0]++;
      end
      if (b_valid) begin
        if (sb_b.size() == 0) fail_now("b.table_extra");
        else check("b.table", 32'(b_data), 32'(sb_b.pop_front()));
        sb_out[1]++;
      end
    end
  endtask

  task automatic wait_a_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (a_state !== s && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(a_state), 32'(s));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] got [$];
    logic [27:0] exp_fill;
    int          first, last, cyc, n, p;
    logic [15:0] ucnt_held;

    m_pl[0] = 8;  m_sh[0] = 0;
    m_pl[1] = 16; m_sh[1] = 2;
    tbl[0] = '{16'h7FFF, 16'h8000, 14'h1FFF, 14'h2000, 14'h1FFF, 14'h2000};
    tbl[1] = '{16'h0064, 16'hFF9C, 14'h0064, 14'h3F9C, 14'h0019, 14'h3FE7};
    tbl[2] = '{16'h1FFF, 16'hE000, 14'h1FFF, 14'h2000, 14'h07FF, 14'h3800};
    tbl[3] = '{16'h2000, 16'hDFFF, 14'h1FFF, 14'h2000, 14'h0800, 14'h37FF};
    tbl[4] = '{16'h0003, 16'hFFFF, 14'h0003, 14'h3FFF, 14'h0000, 14'h3FFF};
    tbl[5] = '{16'h1234, 16'h8001, 14'h1234, 14'h2000, 14'h048D, 14'h2000};
    sb_acc[0] = 0; sb_acc[1] = 0; sb_out[0] = 0; sb_out[1] = 0;

    // Reset.
    rst_n = 1'b1; enable = 1'b0; pll_locked = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.state",  32'(a_state),  32'd0);
    check("reset.level",  32'(a_level),  32'd0);
    check("reset.data",   32'(a_data),   32'd0);
    check("reset.valid",  32'(a_valid),  32'd0);
    check("reset.tready", 32'(a_tready), 32'd0);
    check("reset.ucnt",   32'(a_ucnt),   32'd0);
    check("reset.sat",    32'(a_sat),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Startup: wait for lock, then prime and stream 100..115.
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("startup.wait_state",  32'(a_state),  32'd1);
      check("startup.wait_tready", 32'(a_tready), 32'd0);
    end
    pll_locked = 1'b1;
    tick();
    check("startup.prime_state",  32'(a_state),  32'd2);
    check("startup.prime_tready", 32'(a_tready), 32'd1);
    first = -1; last = -1; cyc = 0;
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = {16'(1000 + 100 + i), 16'(100 + i)};
      tick();
      check("startup.run_entry", 32'(a_state), (i < 8) ? 32'd2 : 32'd3);
      if (a_valid) begin got.push_back(a_data[13:0]); if (first < 0) first = cyc; last = cyc; end
      cyc++;
    end
    s_tvalid = 1'b0;
    n = 0;
    while (a_state !== 3'd4 && n < 64) begin
      tick();
      if (a_valid) begin got.push_back(a_data[13:0]); if (first < 0) first = cyc; last = cyc; end
      cyc++;
      n++;
    end
    check("startup.count",  32'(got.size()), 32'd16);
    check("startup.nogap",  32'(last - first + 1), 32'd16);
    for (int i = 0; i < got.size(); i++) check("startup.ch0", 32'(got[i]), 32'(100 + i));

    // Underrun after drain.
`ifdef DAC_RP_STREAM_HOLD_EN
    exp_fill = {14'd1115, 14'd115};
`else
    exp_fill = '0;
`endif
    check("underrun.state", 32'(a_state), 32'd4);
    check("underrun.ucnt",  32'(a_ucnt),  32'd1);
    check("underrun.valid", 32'(a_valid), 32'd0);
    check("underrun.data",  32'(a_data),  32'(exp_fill));

    // Refill 8 beats to resume.
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = {16'(300 + i), 16'(200 + i)};
      tick();
    end
    check("refill.still_under", 32'(a_state), 32'd4);
    s_tvalid = 1'b0;
    tick();
    check("refill.run", 32'(a_state), 32'd3);

    // Lock loss mid-run.
    pll_locked = 1'b0;
    tick();
    check("lockloss.state", 32'(a_state), 32'd1);
    check("lockloss.level", 32'(a_level), 32'd0);
    check("lockloss.data",  32'(a_data),  32'd0);

    // Disable.
    pll_locked = 1'b1;
    enable = 1'b0;
    tick();
    check("disable.state", 32'(a_state), 32'd0);
    check("disable.ucnt",  32'(a_ucnt),  32'd1);

    // Table vectors, continuous valid: saturation and backpressure scoreboard.
    enable = 1'b1;
    tbl_mode = 1'b1;
    for (int k = 0; k < 64; k++) begin
      cur_idx  = k % 6;
      s_tvalid = 1'b1;
      s_tdata  = {tbl[cur_idx].x1, tbl[cur_idx].x0};
      tick();
    end
    s_tvalid = 1'b0;
    n = 0;
    while ((a_state !== 3'd4 || b_state !== 3'd4) && n < 200) begin
      tick();
      n++;
    end
    tbl_mode = 1'b0;
    check("table.a_drained", 32'(a_state), 32'd4);
    check("table.b_drained", 32'(b_state), 32'd4);
    check("table.a_all_out", 32'(sb_out[0]), 32'(sb_acc[0]));
    check("table.b_all_out", 32'(sb_out[1]), 32'(sb_acc[1]));
    check("table.a_sat", 32'(a_sat), 32'd3);
    check("table.b_sat", 32'(b_sat), 32'd0);
    check("table.a_ucnt", 32'(a_ucnt), 32'd2);
    ucnt_held = a_ucnt;

    enable = 1'b0;
    tick();
    check("disable2.state", 32'(a_state), 32'd0);
    check("disable2.sat",   32'(a_sat),   32'd0);
    check("disable2.ucnt",  32'(a_ucnt),  32'd2);

    // Randomized traffic with occasional disable and lock loss.
    p = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) p = int'($urandom_range(1, 4));
      enable     = ($urandom_range(0, 199) != 0);
      pll_locked = ($urandom_range(0, 149) != 0);
      s_tvalid   = (int'($urandom_range(0, 3)) < p);
      s_tdata    = $urandom;
      tick();
    end

    // Asynchronous reset between edges while running.
    enable = 1'b1; pll_locked = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h0010_0020;
    wait_a_state(3'd3, 64, "areset.reach_run");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset.state",  32'(a_state),  32'd0);
    check("areset.level",  32'(a_level),  32'd0);
    check("areset.data",   32'(a_data),   32'd0);
    check("areset.valid",  32'(a_valid),  32'd0);
    check("areset.tready", 32'(a_tready), 32'd0);
    check("areset.ucnt",   32'(a_ucnt),   32'd0);
    check("areset.sat",    32'(a_sat),    32'd0);
    check("areset.b_state", 32'(b_state), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
